rf_port_arbiter: RTL and testbench

RF_PORT_ARBITER -- requirements
Module: rf_port_arbiter

---
 rtl/rf_arb_pkg.sv | 20 ++
 rtl/rf_port_arbiter_if.sv | 46 ++++
 rtl/rf_rr_picker.sv | 38 +++
 rtl/rf_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_rf_port_arbiter.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/rf_arb_pkg.sv
// Shared types and default sizing for the register-file port arbiter.
// The optional statistics counters are enabled with the RF_ARB_STATS_EN macro.
package rf_arb_pkg;

    localparam int NREQ_DEF   = 2;
    localparam int SEL_W_DEF  = 18;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    // Width of a requester index; a lone requester still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rf_port_arbiter_if.sv
// Requester-side handshake and register-file bus of the port arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface rf_port_arbiter_if
    import rf_arb_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int SEL_W  = SEL_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    // requester request channel
    logic [NREQ-1:0]              req_valid;
    logic [NREQ-1:0]              req_ready;
    logic [NREQ-1:0]              req_wen;
    logic [NREQ-1:0][SEL_W-1:0]   req_wsel;
    logic [NREQ-1:0][SEL_W-1:0]   req_rsel1;
    logic [NREQ-1:0][SEL_W-1:0]   req_rsel2;
    logic [NREQ-1:0][DATA_W-1:0]  req_wdat;
    // requester response channel
    logic [NREQ-1:0]              rsp_valid;
    logic [NREQ-1:0]              rsp_ready;
    logic [DATA_W-1:0]            rsp_rdat1;
    logic [DATA_W-1:0]            rsp_rdat2;
    // register-file side
    logic                         WEN;
    logic [SEL_W-1:0]             wsel;
    logic [SEL_W-1:0]             rsel1;
    logic [SEL_W-1:0]             rsel2;
    logic [DATA_W-1:0]            wdat;
    logic [DATA_W-1:0]            rdat1;
    logic [DATA_W-1:0]            rdat2;

    modport slave (
        input  req_valid, req_wen, req_wsel, req_rsel1, req_rsel2, req_wdat,
        input  rsp_ready, rdat1, rdat2,
        output req_ready, rsp_valid, rsp_rdat1, rsp_rdat2,
        output WEN, wsel, rsel1, rsel2, wdat
    );

    modport master (
        output req_valid, req_wen, req_wsel, req_rsel1, req_rsel2, req_wdat,
        output rsp_ready, rdat1, rdat2,
        input  req_ready, rsp_valid, rsp_rdat1, rsp_rdat2,
        input  WEN, wsel, rsel1, rsel2, wdat
    );

endinterface

// File: rtl/rf_rr_picker.sv
// Combinational round-robin pick: the first valid requester at or after
// ptr_i (wrapping) wins; returns a one-hot grant and its index.
module rf_rr_picker #(
    parameter int NREQ  = 2,
    parameter int IDX_W = 1
) (
    input  logic [NREQ-1:0]  valid_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    // cand[k] is the requester examined at priority rank k
    logic [IDX_W-1:0] cand [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cand
            assign cand[gi] = IDX_W'((int'(ptr_i) + gi) % NREQ);
        end
    endgenerate

    // Scan ranks in order and keep the first valid candidate.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any_o && valid_i[cand[k]]) begin
                any_o          = 1'b1;
                grant_o[cand[k]] = 1'b1;
                idx_o          = cand[k];
            end
        end
    end

endmodule

// File: rtl/rf_port_arbiter.sv
// Shares one register-file port among NREQ requesters. Each transaction runs
// IDLE (grant) -> ISSUE (drive RF one cycle) -> RESP (hold data until taken).
// Define RF_ARB_STATS_EN to add the grant_cnt / conflict_cnt counters.
module rf_port_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int SEL_W  = SEL_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    rf_port_arbiter_if.slave   bus
`ifdef RF_ARB_STATS_EN
    ,
    output logic [31:0]        grant_cnt,
    output logic [31:0]        conflict_cnt
`endif
);

    localparam int IDX_W = idx_width(NREQ);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    id_q, id_d;
    logic                wen_q, wen_d;
    logic [SEL_W-1:0]    wsel_q, wsel_d, rsel1_q, rsel1_d, rsel2_q, rsel2_d;
    logic [DATA_W-1:0]   wdat_q, wdat_d;
    logic [DATA_W-1:0]   rdat1_q, rdat1_d, rdat2_q, rdat2_d;

    logic [NREQ-1:0]     win_grant;
    logic [IDX_W-1:0]    win_idx;
    logic                win_any;

    rf_rr_picker #(.NREQ(NREQ), .IDX_W(IDX_W)) u_picker (
        .valid_i (bus.req_valid),
        .ptr_i   (ptr_q),
        .grant_o (win_grant),
        .idx_o   (win_idx),
        .any_o   (win_any)
    );

    // Next-state and bus outputs; reset forces every output quiet in the
    // same cycle so an interrupted ISSUE never reaches the register file.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        id_d          = id_q;
        wen_d         = wen_q;
        wsel_d        = wsel_q;
        rsel1_d       = rsel1_q;
        rsel2_d       = rsel2_q;
        wdat_d        = wdat_q;
        rdat1_d       = rdat1_q;
        rdat2_d       = rdat2_q;
        bus.req_ready = '0;
        bus.rsp_valid = '0;
        bus.WEN       = 1'b0;
        bus.wsel      = '0;
        bus.rsel1     = '0;
        bus.rsel2     = '0;
        bus.wdat      = '0;
        unique case (state_q)
            IDLE: begin
                if (win_any) begin
                    bus.req_ready = win_grant;
                    id_d          = win_idx;
                    wen_d         = bus.req_wen[win_idx];
                    wsel_d        = bus.req_wsel[win_idx];
                    rsel1_d       = bus.req_rsel1[win_idx];
                    rsel2_d       = bus.req_rsel2[win_idx];
                    wdat_d        = bus.req_wdat[win_idx];
                    ptr_d         = (win_idx == IDX_W'(NREQ - 1)) ? '0 : win_idx + IDX_W'(1);
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                bus.WEN   = wen_q;
                bus.wsel  = wsel_q;
                bus.rsel1 = rsel1_q;
                bus.rsel2 = rsel2_q;
                bus.wdat  = wdat_q;
                rdat1_d   = bus.rdat1;
                rdat2_d   = bus.rdat2;
                state_d   = RESP;
            end
            RESP: begin
                bus.rsp_valid[id_q] = 1'b1;
                if (bus.rsp_ready[id_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (RST) begin
            bus.req_ready = '0;
            bus.rsp_valid = '0;
            bus.WEN       = 1'b0;
            bus.wsel      = '0;
            bus.rsel1     = '0;
            bus.rsel2     = '0;
            bus.wdat      = '0;
        end
    end

    // State, pointer, captured request and response data registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            wen_q   <= 1'b0;
            wsel_q  <= '0;
            rsel1_q <= '0;
            rsel2_q <= '0;
            wdat_q  <= '0;
            rdat1_q <= '0;
            rdat2_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            wen_q   <= wen_d;
            wsel_q  <= wsel_d;
            rsel1_q <= rsel1_d;
            rsel2_q <= rsel2_d;
            wdat_q  <= wdat_d;
            rdat1_q <= rdat1_d;
            rdat2_q <= rdat2_d;
        end
    end

    assign bus.rsp_rdat1 = rdat1_q;
    assign bus.rsp_rdat2 = rdat2_q;

`ifdef RF_ARB_STATS_EN
    logic [31:0] grant_cnt_q, conflict_cnt_q;
    logic        multi_valid;

    assign multi_valid = |(bus.req_valid & (bus.req_valid - NREQ'(1)));

    // Grants, and cycles where some requester had to wait; both wrap.
    always_ff @(posedge CLK) begin
        if (RST) begin
            grant_cnt_q    <= '0;
            conflict_cnt_q <= '0;
        end else begin
            if (state_q == IDLE && win_any) begin
                grant_cnt_q <= grant_cnt_q + 32'd1;
            end
            if ((state_q == IDLE && multi_valid) || (state_q != IDLE && |bus.req_valid)) begin
                conflict_cnt_q <= conflict_cnt_q + 32'd1;
            end
        end
    end

    assign grant_cnt    = grant_cnt_q;
    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Directed bench for rf_port_arbiter with a small behavioural register file.
module tb_rf_port_arbiter;

    localparam int NREQ   = 2;
    localparam int SEL_W  = 18;
    localparam int DATA_W = 32;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

`ifdef RF_ARB_STATS_EN
    logic [31:0] grant_cnt;
    logic [31:0] conflict_cnt;
`endif

    rf_port_arbiter_if #(.NREQ(NREQ), .SEL_W(SEL_W), .DATA_W(DATA_W)) bus ();

    rf_port_arbiter #(.NREQ(NREQ), .SEL_W(SEL_W), .DATA_W(DATA_W)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
`ifdef RF_ARB_STATS_EN
        ,
        .grant_cnt    (grant_cnt),
        .conflict_cnt (conflict_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // register file model: 32 entries, preloaded r5=0xA, r7=0xB on reset
    logic [31:0] mem [0:31];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
            mem[5] <= 32'h0000_000A;
            mem[7] <= 32'h0000_000B;
        end else if (bus.WEN) begin
            mem[bus.wsel[4:0]] <= bus.wdat;
        end
    end
    assign bus.rdat1 = mem[bus.rsel1[4:0]];
    assign bus.rdat2 = mem[bus.rsel2[4:0]];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] exp_oh;

    initial begin
        checks         = 0;
        failures       = 0;
        rst            = 1'b1;
        bus.req_valid  = 2'b11;
        bus.req_wen    = '0;
        bus.req_wsel   = '0;
        bus.req_rsel1  = '0;
        bus.req_rsel2  = '0;
        bus.req_wdat   = '0;
        bus.rsp_ready  = '0;

        // reset: everything quiet even with requests pending
        tick(); #1;
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_wen",       64'(bus.WEN),       64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rdat1",     64'(bus.rsp_rdat1), 64'd0);

        // single read by req0, response backpressured
        tick();
        rst                = 1'b0;
        bus.req_valid      = 2'b01;
        bus.req_rsel1[0]   = 18'd5;
        bus.req_rsel2[0]   = 18'd7;
        bus.req_wen[1]     = 1'b1;
        bus.req_wsel[1]    = 18'd3;
        bus.req_wdat[1]    = 32'hDEADBEEF;
        bus.rsp_ready      = 2'b10;
        #1;
        chk("rd_ready_T",    64'(bus.req_ready), 64'h1);
        chk("rd_rsp_T",      64'(bus.rsp_valid), 64'h0);
        tick();
        bus.req_valid = 2'b10;
        #1;
        chk("rd_rsel1_T1",   64'(bus.rsel1),     64'd5);
        chk("rd_rsel2_T1",   64'(bus.rsel2),     64'd7);
        chk("rd_wen_T1",     64'(bus.WEN),       64'd0);
        chk("rd_ready_T1",   64'(bus.req_ready), 64'd0);
        tick(); #1;
        chk("rd_rsp_T2",     64'(bus.rsp_valid), 64'h1);
        chk("rd_rdat1_T2",   64'(bus.rsp_rdat1), 64'hA);
        chk("rd_rdat2_T2",   64'(bus.rsp_rdat2), 64'hB);
        chk("rd_rsel1_T2",   64'(bus.rsel1),     64'd0);
        for (int c = 0; c < 4; c++) begin
            tick(); #1;
            chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'h1);
            chk("bp_rdat1",     64'(bus.rsp_rdat1), 64'hA);
            chk("bp_rdat2",     64'(bus.rsp_rdat2), 64'hB);
            chk("bp_ready",     64'(bus.req_ready), 64'h0);
            chk("bp_wen",       64'(bus.WEN),       64'h0);
            chk("bp_rsel1",     64'(bus.rsel1),     64'h0);
        end

        // response taken; waiting write from req1 wins next
        bus.rsp_ready = 2'b11;
        tick(); #1;
        chk("wr_ready_T",    64'(bus.req_ready), 64'h2);
        tick();
        bus.req_valid = 2'b00;
        #1;
        chk("wr_wen_T1",     64'(bus.WEN),       64'd1);
        chk("wr_wsel_T1",    64'(bus.wsel),      64'd3);
        chk("wr_wdat_T1",    64'(bus.wdat),      64'hDEADBEEF);
        tick(); #1;
        chk("wr_wen_T2",     64'(bus.WEN),       64'd0);
        chk("wr_wsel_T2",    64'(bus.wsel),      64'd0);
        chk("wr_rsp_T2",     64'(bus.rsp_valid), 64'h2);

        // read back r3 (and r5) through req0
        tick();
        bus.req_valid    = 2'b01;
        bus.req_rsel1[0] = 18'd3;
        bus.req_rsel2[0] = 18'd5;
        #1;
        chk("rb_ready_T",    64'(bus.req_ready), 64'h1);
        tick();
        bus.req_valid = 2'b00;
        tick(); #1;
        chk("rb_rsp_T2",     64'(bus.rsp_valid), 64'h1);
        chk("rb_rdat1",      64'(bus.rsp_rdat1), 64'hDEADBEEF);
        chk("rb_rdat2",      64'(bus.rsp_rdat2), 64'hA);

        // contention from reset: grants alternate 0,1,0,1
        rst = 1'b1;
        tick();
        rst           = 1'b0;
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            exp_oh = (k % 2 == 0) ? 2'b01 : 2'b10;
            chk("ct_ready", 64'(bus.req_ready), 64'(exp_oh));
            tick();
            tick(); #1;
            chk("ct_rsp",   64'(bus.rsp_valid), 64'(exp_oh));
            tick(); #1;
        end
`ifdef RF_ARB_STATS_EN
        chk("ct_grant_cnt",    64'(grant_cnt),    64'd4);
        chk("ct_conflict_cnt", 64'(conflict_cnt), 64'd12);
`endif

        // lone requester wins against ptr=0, then reset lands in its ISSUE
        bus.req_valid   = 2'b10;
        bus.req_wsel[1] = 18'd9;
        bus.req_wdat[1] = 32'h0000_1234;
        #1;
        chk("single_ready",  64'(bus.req_ready), 64'h2);
        tick();
        bus.req_valid = 2'b00;
        #1;
        chk("ri_wen_pre",    64'(bus.WEN),       64'd1);
        rst = 1'b1;
        #1;
        chk("ri_wen_rst",    64'(bus.WEN),       64'd0);
        chk("ri_wsel_rst",   64'(bus.wsel),      64'd0);
        tick();
        rst           = 1'b0;
        bus.req_valid = 2'b11;
        #1;
        chk("ri_rsp_after",  64'(bus.rsp_valid), 64'h0);
        chk("ri_ready_after",64'(bus.req_ready), 64'h1);
        tick();
        bus.req_valid = 2'b00;
        #1;
        chk("ri_rsp_issue",  64'(bus.rsp_valid), 64'h0);
        tick(); #1;
        chk("ri_rsp_done",   64'(bus.rsp_valid), 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
